// File: rtl/display_frame_seq_pkg.sv
// Shared constants, LFSR helper and FSM state type for the display frame sequencer.
package display_frame_seq_pkg;

  localparam int unsigned LFSR_W = 32;

  // x^32 + x^22 + x^2 + x + 1 -> state bits 31, 21, 1, 0
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/display_frame_seq_if.sv
// Start/frame handshake bundle between a sequence requester and the frame sequencer.
interface display_frame_seq_if
  import display_frame_seq_pkg::*;
#(
  parameter int unsigned NB_SEGMENTS = 7,
  parameter int unsigned NB_FRAMES   = 8
);
  localparam int unsigned IDX_W = (NB_FRAMES > 1) ? $clog2(NB_FRAMES) : 1;

  logic                   start;
  logic [NB_SEGMENTS-1:0] msg;
  logic [LFSR_W-1:0]      seed;
  logic                   frame_valid;
  logic                   frame_ready;
  logic [NB_SEGMENTS-1:0] frame_seg;
  logic [IDX_W-1:0]       frame_idx;
  logic                   busy;
  logic                   done;

  modport master (
    output start, msg, seed, frame_ready,
    input  frame_valid, frame_seg, frame_idx, busy, done
  );

  modport slave (
    input  start, msg, seed, frame_ready,
    output frame_valid, frame_seg, frame_idx, busy, done
  );

endinterface

// File: rtl/display_lfsr_step.sv
// Combinational advance of the sequencer LFSR by a fixed number of steps.
module display_lfsr_step
  import display_frame_seq_pkg::*;
#(
  parameter int unsigned Steps = 1
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] s;

  always_comb begin
    s = state_i;
    for (int unsigned i = 0; i < Steps; i++) begin
      s = lfsr_next(s);
    end
    state_o = s;
  end

endmodule

// File: rtl/display_frame_seq.sv
// Generates NB_FRAMES pseudo-random segment frames per message: displayed segments
// light at 1/2 duty, undisplayed ones at 1/4, over a valid/ready frame handshake.
module display_frame_seq
  import display_frame_seq_pkg::*;
#(
  parameter int unsigned NB_SEGMENTS = 7,
  parameter int unsigned NB_FRAMES   = 8
) (
  input  logic               clk,
  input  logic               rst,
  display_frame_seq_if.slave bus
);

  localparam int unsigned IDX_W = (NB_FRAMES > 1) ? $clog2(NB_FRAMES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_FRAMES - 1);

  state_e                 state_q, state_d;
  logic [LFSR_W-1:0]      lfsr_q, lfsr_d, lfsr_adv, seed_fix;
  logic [NB_SEGMENTS-1:0] msg_q, msg_d;
  logic [NB_SEGMENTS-1:0] seg_q, seg_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   hs;

  display_lfsr_step #(
    .Steps(2 * NB_SEGMENTS)
  ) u_step (
    .state_i(lfsr_q),
    .state_o(lfsr_adv)
  );

  // Displayed segments take r_a alone; others need r_a and r_b both set.
  function automatic logic [NB_SEGMENTS-1:0] mix(input logic [NB_SEGMENTS-1:0] m,
                                                 input logic [LFSR_W-1:0]      s);
    logic [NB_SEGMENTS-1:0] ra, rb;
    ra = s[NB_SEGMENTS-1:0];
    rb = s[2*NB_SEGMENTS-1:NB_SEGMENTS];
    return (m & ra) | (~m & ra & rb);
  endfunction

  // A zero seed would lock the LFSR.
  assign seed_fix = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
  assign hs       = (state_q == StRun) && bus.frame_ready;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    msg_d   = msg_q;
    seg_d   = seg_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          lfsr_d  = seed_fix;
          msg_d   = bus.msg;
          seg_d   = mix(bus.msg, seed_fix);
          idx_d   = '0;
        end
      end
      StRun: begin
        if (hs) begin
          lfsr_d = lfsr_adv;
          if (idx_q == LAST_IDX) begin
            state_d = StDone;
            seg_d   = '0;
          end else begin
            seg_d = mix(msg_q, lfsr_adv);
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= '0;
      msg_q   <= '0;
      seg_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      msg_q   <= msg_d;
      seg_q   <= seg_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    bus.frame_valid = (state_q == StRun);
    bus.frame_seg   = (state_q == StRun) ? seg_q : '0;
    bus.frame_idx   = idx_q;
    bus.busy        = (state_q != StIdle);
    bus.done        = (state_q == StDone);
  end

endmodule

// File: tb/tb_display_frame_seq.sv
// Randomised self-checking bench for display_frame_seq against a frame-level reference model.
module tb_display_frame_seq;

  localparam int NS = 7;
  localparam int NF = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [NS-1:0] got[NF];
  logic [NS-1:0] g0[NF];

  display_frame_seq_if #(.NB_SEGMENTS(NS), .NB_FRAMES(NF)) bus ();
  display_frame_seq_if #(.NB_SEGMENTS(NS), .NB_FRAMES(1))  bus1 ();

  display_frame_seq #(.NB_SEGMENTS(NS), .NB_FRAMES(NF)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  display_frame_seq #(.NB_SEGMENTS(NS), .NB_FRAMES(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: state of the LFSR after n single shifts.
  function automatic logic [31:0] ref_adv(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    return s;
  endfunction

  // Segment i lit when r_a[i] and (displayed or r_b[i]).
  function automatic logic [NS-1:0] ref_seg(input logic [NS-1:0] m, input logic [31:0] st);
    logic [NS-1:0] ra, rb;
    ra = st[NS-1:0];
    rb = st[2*NS-1:NS];
    return ra & (m | rb);
  endfunction

  // mode 0: always ready, 1: ready toggles, 2: random ready. perturb drives start/msg/seed in RUN.
  task automatic run_seq(input logic [NS-1:0] m, input logic [31:0] s, input int mode,
                         input bit perturb);
    logic [31:0]   st;
    logic [NS-1:0] expv;
    int            k;
    int            cyc;
    bit            rdy;
    st = (s == 0) ? 32'd1 : s;
    @(negedge clk);
    bus.start = 1'b1; bus.msg = m; bus.seed = s; bus.frame_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < NF && cyc < 400) begin
      expv = ref_seg(m, st);
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.frame_idx !== 3'(k) || bus.frame_seg !== expv ||
          bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL frame k=%0d: valid=%b idx=%0d seg=%h busy=%b done=%b, want 1 %0d %h 1 0",
                 k, bus.frame_valid, bus.frame_idx, bus.frame_seg, bus.busy, bus.done, k, expv);
      end
      got[k] = bus.frame_seg;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      bus.frame_ready = rdy;
      if (perturb) begin
        bus.start = 1'b1;
        bus.msg   = NS'($urandom);
        bus.seed  = $urandom;
      end
      @(negedge clk);
      if (rdy) begin
        k++;
        st = ref_adv(st, 2 * NS);
      end
      cyc++;
    end
    bus.frame_ready = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (k < NF) begin
      errors++;
      $display("FAIL timeout: handshakes=%0d, want %0d", k, NF);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.frame_valid !== 1'b0 || bus.frame_seg !== '0 ||
        bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: done=%b valid=%b seg=%h busy=%b, want 1 0 0 1",
               bus.done, bus.frame_valid, bus.frame_seg, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_idle: done=%b busy=%b valid=%b, want 0 0 0",
               bus.done, bus.busy, bus.frame_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.frame_seg !== '0 || bus.frame_idx !== '0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || dut.lfsr_q !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b seg=%h idx=%0d busy=%b done=%b lfsr=%h, want all 0",
               bus.frame_valid, bus.frame_seg, bus.frame_idx, bus.busy, bus.done, dut.lfsr_q);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_seq(7'h7F, 32'd1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_seq(7'h7F, 32'd1, 1, 1'b0);
    run_seq(NS'($urandom), $urandom, 2, 1'b0);
  endtask

  task automatic test_zero();
    logic [31:0] st;
    run_seq('0, 32'd0, 0, 1'b0);
    for (int k = 0; k < NF; k++) g0[k] = got[k];
    run_seq('0, 32'd1, 0, 1'b0);
    st = 32'd1;
    for (int k = 0; k < NF; k++) begin
      checks++;
      if (g0[k] !== got[k] || g0[k] !== (st[NS-1:0] & st[2*NS-1:NS])) begin
        errors++;
        $display("FAIL zero_seed k=%0d: seed0=%h seed1=%h, want %h",
                 k, g0[k], got[k], st[NS-1:0] & st[2*NS-1:NS]);
      end
      st = ref_adv(st, 2 * NS);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus.start = 1'b1; bus.msg = 7'h7F; bus.seed = $urandom; bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.frame_idx !== 3'd3 || bus.frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: idx=%0d valid=%b, want 3 1", bus.frame_idx, bus.frame_valid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.frame_seg !== '0 || bus.frame_idx !== '0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: valid=%b seg=%h idx=%0d busy=%b done=%b, want all 0",
               bus.frame_valid, bus.frame_seg, bus.frame_idx, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done cyc=%0d: done=%b busy=%b, want 0 0", i, bus.done, bus.busy);
      end
    end
    bus.frame_ready = 1'b0;
    run_seq(NS'($urandom), $urandom, 0, 1'b0);
  endtask

  task automatic test_busy_start();
    run_seq(NS'($urandom), $urandom, 2, 1'b1);
    run_seq(7'h7F, 32'd1, 1, 1'b1);
  endtask

  task automatic test_stats();
    int disp_on, disp_tot, und_on, und_tot;
    disp_on = 0; disp_tot = 0; und_on = 0; und_tot = 0;
    for (int q = 0; q < 4096 / NF; q++) begin
      run_seq(7'h55, $urandom, 0, 1'b0);
      for (int k = 0; k < NF; k++) begin
        for (int i = 0; i < NS; i++) begin
          if (i % 2 == 0) begin
            disp_tot++;
            disp_on += int'(got[k][i]);
          end else begin
            und_tot++;
            und_on += int'(got[k][i]);
          end
        end
      end
    end
    checks++;
    if (disp_on * 100 < 47 * disp_tot || disp_on * 100 > 53 * disp_tot) begin
      errors++;
      $display("FAIL duty_displayed: %0d of %0d lit, want 0.47..0.53", disp_on, disp_tot);
    end
    checks++;
    if (und_on * 100 < 22 * und_tot || und_on * 100 > 28 * und_tot) begin
      errors++;
      $display("FAIL duty_undisplayed: %0d of %0d lit, want 0.22..0.28", und_on, und_tot);
    end
  endtask

  task automatic test_single();
    logic [NS-1:0] m;
    logic [31:0]   s;
    m = NS'($urandom);
    s = $urandom;
    @(negedge clk);
    bus1.start = 1'b1; bus1.msg = m; bus1.seed = s; bus1.frame_ready = 1'b0;
    @(negedge clk);
    bus1.start = 1'b0;
    checks++;
    if (bus1.frame_valid !== 1'b1 || bus1.frame_idx !== 1'b0 ||
        bus1.frame_seg !== ref_seg(m, (s == 0) ? 32'd1 : s)) begin
      errors++;
      $display("FAIL single_frame: valid=%b idx=%0d seg=%h, want 1 0 %h", bus1.frame_valid,
               bus1.frame_idx, bus1.frame_seg, ref_seg(m, (s == 0) ? 32'd1 : s));
    end
    bus1.frame_ready = 1'b1;
    @(negedge clk);
    bus1.frame_ready = 1'b0;
    checks++;
    if (bus1.done !== 1'b1 || bus1.frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b valid=%b, want 1 0", bus1.done, bus1.frame_valid);
    end
    @(negedge clk);
    checks++;
    if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: done=%b busy=%b, want 0 0", bus1.done, bus1.busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.start = 1'b0; bus.msg = '0; bus.seed = '0; bus.frame_ready = 1'b0;
    bus1.start = 1'b0; bus1.msg = '0; bus1.seed = '0; bus1.frame_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_abort();
    test_busy_start();
    test_single();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_frame_seq.md
DISPLAY_FRAME_SEQ -- requirements
Module: display_frame_seq

Interface
REQ-001 Parameter NB_SEGMENTS, default 7: segments per bitmap, legal range 1..16.
REQ-002 Parameter NB_FRAMES, default 8: frames generated per message, legal range 1..256.
REQ-003 Parameter LFSR_W, fixed 32: random state width.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port start, input, 1: request a new frame sequence; sampled only in IDLE.
REQ-007 Port msg, input, NB_SEGMENTS: segments to display; latched on accepted start.
REQ-008 Port seed, input, 32: LFSR seed; latched on accepted start.
REQ-009 Port frame_valid, output, 1: frame_seg and frame_idx are valid.
REQ-010 Port frame_ready, input, 1: downstream accepts the current frame.
REQ-011 Port frame_seg, output, NB_SEGMENTS: segments lit in the current frame; feeds segment2pixel.
REQ-012 Port frame_idx, output, clog2(NB_FRAMES) (min 1): index of the current frame, 0-based.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port done, output, 1: one-cycle pulse after the last frame is accepted.

Function
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 IDLE and start=1: latch msg and seed, set frame_idx=0, go to RUN next cycle.
REQ-017 Seed 0 is latched as 32'h0000_0001; the all-zero LFSR state is unreachable.
REQ-018 LFSR: Fibonacci, polynomial x^32+x^22+x^2+x+1, shift left, feedback into bit 0.
REQ-019 Per frame, r_a = state[NB_SEGMENTS-1:0] and r_b = state[2*NB_SEGMENTS-1:NB_SEGMENTS].
REQ-020 Segment i: frame_seg[i] = msg[i] ? r_a[i] : (r_a[i] & r_b[i]), so displayed segments have 1/2 duty and undisplayed segments 1/4 duty.
REQ-021 frame_valid=1 throughout RUN; frame_seg is registered and valid in the first RUN cycle (latency 2 cycles from start).
REQ-022 Handshake occurs when frame_valid and frame_ready are both 1 on a clock edge.
REQ-023 While frame_valid=1 and frame_ready=0, frame_seg and frame_idx hold stable.
REQ-024 On a handshake the LFSR advances exactly 2*NB_SEGMENTS steps (combinationally unrolled, one cycle) and frame_idx increments.
REQ-025 Handshakes may occur on consecutive cycles (1 frame/cycle); no bubble is inserted.
REQ-026 A handshake at frame_idx = NB_FRAMES-1 moves the FSM to DONE with frame_valid=0; frame_idx never wraps inside a sequence.
REQ-027 DONE: assert done for one cycle, then return to IDLE.
REQ-028 start outside IDLE is ignored; msg and seed changes outside IDLE have no effect.
REQ-029 With NB_FRAMES=1, a single handshake leads directly to DONE.
REQ-030 In IDLE and DONE, frame_valid=0 and frame_seg=0.

Reset
REQ-031 While rst=1: state=IDLE, and frame_valid, frame_seg, frame_idx, busy, done, and the LFSR are 0, independent of clk.
REQ-032 Reset asserted mid-sequence aborts the sequence with no done pulse; the next start begins afresh.

Structure
REQ-033 A shared package holds the LFSR polynomial taps, the LFSR_W constant, and the FSM state enum.
REQ-034 One sub-module, display_lfsr_step, SHALL implement the parametrised N-step combinational LFSR advance.

Verification
REQ-035 Basic sequence: NB_SEGMENTS=7, NB_FRAMES=8, msg=7'h7F, seed=1, frame_ready=1 -> 8 consecutive frames, frame_idx 0..7, frame_seg matches the reference model, done pulses at cycle 10 after start.
REQ-036 Backpressure: frame_ready toggles 0/1 each cycle -> frame_seg stable while not ready, same 8-frame sequence as REQ-035, done after the 8th handshake.
REQ-037 Zero handling: seed=0 and msg=0 -> output identical to seed=1, and every frame_seg bit equals r_a&r_b.
REQ-038 Mid-sequence reset and busy start: rst pulsed at frame_idx=3 -> outputs 0 immediately and no done; start during RUN -> ignored, with msg and seed unchanged.
REQ-039 Statistics: 4096 frames, msg=7'h55 -> displayed-segment duty 0.5±0.03, undisplayed-segment duty 0.25±0.03.
REQ-040 Single frame: NB_FRAMES=1 -> one handshake, frame_idx=0, done next cycle.
